alu_bit_serial_sequencer: RTL
=============================

Name: alu_bit_serial_sequencer

Overview:
- Sequences one 1-bit ALU slice over a WIDTH-bit operand pair, LSB first, one bit per clock.
- The slice provides full adder, subtractor (A + ~B + carry), AND, OR, XOR, NOT and pass-through.
- The block owns operand capture, the carry register, the bit counter, result assembly, flag generation and the start/done handshake.
- It is the control layer between the instruction front end and the bit-slice operation cells.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32. The internal bit counter is sized ceil(log2(WIDTH))+1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request to begin an operation; sampled only in IDLE
- opcode  input  3  operation select, captured with start
- a  input  WIDTH  operand A, captured with start
- b  input  WIDTH  operand B, captured with start
- busy  output  1  high whenever state is not IDLE
- done  output  1  single-cycle pulse, result and flags valid
- result  output  WIDTH  assembled result, held until next accepted start
- cout  output  1  final carry (ADD/SUB), 0 for logic ops
- ovf  output  1  signed overflow (ADD/SUB), 0 for logic ops
- zero  output  1  high when result == 0

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state=IDLE; busy, done, cout, ovf, zero = 0; result = 0; internal operand, carry and counter registers = 0.
  - Reset overrides every other event, including mid-operation. No done is emitted for an aborted operation.
- Opcodes:
  - 000 ADD
  - 001 SUB (A + ~B + 1)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A (B ignored)
  - 110 PASS A
  - 111 reserved, executes as PASS A
- States: IDLE, RUN, DONE.
  - IDLE: when start=1, capture a, b and opcode. Set carry=1 for SUB, else 0. Set bit counter=0 and go to RUN. result, cout, ovf and zero are cleared on accept.
  - RUN: each edge applies the slice to bit 0 of the A and B shift registers plus the carry register.
    - Shift A and B right by one.
    - Shift the slice output into the MSB of the result shift register (right shift).
    - Carry register takes the slice Cout for ADD/SUB and 0 otherwise.
    - Counter increments.
    - When the counter reaches WIDTH-1 at the edge, that edge processes the final bit and moves to DONE.
  - DONE: done=1 for exactly one cycle, busy stays 1, then unconditional return to IDLE.
- Latency:
  - start accepted at edge k; done is high in the cycle following edge k+WIDTH.
  - A new start can be accepted at edge k+WIDTH+2 at the earliest. With start held high, the throughput is one operation per WIDTH+2 cycles.
- Flags, registered on the edge entering DONE:
  - cout = final carry (ADD/SUB). For SUB, cout=1 means no borrow (A >= B unsigned).
  - ovf = carry into MSB XOR carry out of MSB (ADD/SUB only).
  - zero = (final result == 0), valid for all opcodes.
- start in RUN or DONE is ignored, with no queuing. Operand and opcode inputs are don't-care after capture.
- result and flags remain stable from done until the next accepted start.

Test Plan:
- ADD, WIDTH=8:
  - a=0x5A, b=0x3C -> result=0x96, cout=0, ovf=1, zero=0; done exactly 8 cycles after accept edge, busy high 9 cycles.
  - a=0xFF, b=0x01 -> result=0x00, cout=1, ovf=0, zero=1.
- SUB:
  - a=0x10, b=0x10 -> result=0x00, cout=1, zero=1, ovf=0.
  - a=0x00, b=0x01 -> result=0xFF, cout=0, ovf=0.
  - a=0x80, b=0x01 -> result=0x7F, ovf=1.
- Logic ops:
  - a=0xF0, b=0x3C: AND->0x30, OR->0xFC, XOR->0xCC.
  - NOT A -> 0x0F.
  - PASS and opcode 111 with a=0xA5 -> 0xA5.
  - All logic ops give cout=0, ovf=0.
- start pulsed again with new operands during RUN and during DONE -> ignored; result from first operation only; exactly one done.
- rst_n=0 for one edge while the counter is at 3 -> next cycle busy=0, result=0, no done pulse. A subsequent ADD 0x01+0x01 -> 0x02 with normal latency.
- start held high for 3 operations -> accepts only in IDLE, done pulses spaced exactly WIDTH+2 cycles; zero recomputed per operation.

Source files
------------

// File: rtl/alu_bit_serial_sequencer.sv
// alu_bit_serial_sequencer: runs a 1-bit ALU slice over WIDTH-bit operands, LSB first,
// with operand capture, carry/counter registers, result assembly, flags and start/done handshake.
module alu_bit_serial_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, res_nxt;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             arith, bb, s, co;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end
    // Bit slice: SUB inverts B and relies on the carry preset to 1 at accept.
    always_comb begin
        arith   = op_q[2:1] == 2'b00;
        bb      = b_q[0] ^ (op_q == 3'b001);
        co      = (a_q[0] & bb) | (a_q[0] & carry_q) | (bb & carry_q);
        s       = arith           ? a_q[0] ^ bb ^ carry_q :
                  op_q == 3'b010  ? a_q[0] & b_q[0] :
                  op_q == 3'b011  ? a_q[0] | b_q[0] :
                  op_q == 3'b100  ? a_q[0] ^ b_q[0] :
                  op_q == 3'b101  ? ~a_q[0] : a_q[0];
        res_nxt = {s, res_q[WIDTH-1:1]};
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = a;
                b_d     = b;
                op_d    = opcode;
                carry_d = opcode == 3'b001;
                cnt_d   = '0;
                res_d   = '0;
                cout_d  = 1'b0;
                ovf_d   = 1'b0;
                zero_d  = 1'b0;
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_nxt;
                carry_d = arith & co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cout_d  = arith & co;
                    ovf_d   = arith & (carry_q ^ co);
                    zero_d  = res_nxt == '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy   = state_q != IDLE;
        done   = state_q == DONE;
        result = res_q;
        cout   = cout_q;
        ovf    = ovf_q;
        zero   = zero_q;
    end
endmodule
